// File: rtl/vedic_mult_pipe_if.sv
// Operand/product handshake bundle for vedic_mult_pipe.
// The in_signed lane exists only when VEDIC_SIGNED_EN is defined.
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
`ifdef VEDIC_SIGNED_EN
    logic               in_signed;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               busy;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
`ifdef VEDIC_SIGNED_EN
        output in_signed,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_p,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
`ifdef VEDIC_SIGNED_EN
        input  in_signed,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_p,
        output busy
    );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Two-stage Vedic (quadrant-split) multiplier with valid/ready flow control.
// Define VEDIC_SIGNED_EN to add two's-complement operands via bus.in_signed.
module vedic_mult_pipe #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    vedic_mult_pipe_if.slave  bus
);
    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [W2-1:0]    ZERO_2W = {W2{1'b0}};

    logic                stall_s;
    logic [WIDTH-1:0]    mag_a_s;
    logic [WIDTH-1:0]    mag_b_s;
    logic [WIDTH-1:0]    a_l_s, a_h_s, b_l_s, b_h_s;
    logic [W2-1:0]       sum_raw_s;
    logic [W2-1:0]       sum_s;

    logic                s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0]    q0_d, q0_q, q1_d, q1_q, q2_d, q2_q, q3_d, q3_q;
    logic                out_valid_d, out_valid_q;
    logic [W2-1:0]       out_p_d, out_p_q;
`ifdef VEDIC_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [W2-1:0]    ONE_2W = {{(W2-1){1'b0}}, 1'b1};
    logic                neg_s;
    logic                neg_d, neg_q;
`endif

    // Stall only depends on the output register and the consumer
    always_comb begin
        stall_s = out_valid_q && !bus.out_ready;
    end

    assign bus.in_ready  = !stall_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.busy      = s1_valid_q || out_valid_q;

`ifdef VEDIC_SIGNED_EN
    // Magnitudes are unsigned WIDTH-bit values; the most-negative operand maps to 2^(WIDTH-1)
    always_comb begin
        if (bus.in_signed && bus.in_a[WIDTH-1]) begin
            mag_a_s = ~bus.in_a + ONE_W;
        end else begin
            mag_a_s = bus.in_a;
        end
        if (bus.in_signed && bus.in_b[WIDTH-1]) begin
            mag_b_s = ~bus.in_b + ONE_W;
        end else begin
            mag_b_s = bus.in_b;
        end
        neg_s = bus.in_signed && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
    end
`else
    // Unsigned build: operands pass straight into the quadrant split
    always_comb begin
        mag_a_s = bus.in_a;
        mag_b_s = bus.in_b;
    end
`endif

    // Zero-extend halves so each quadrant product is formed at full WIDTH
    always_comb begin
        a_l_s = {{H{1'b0}}, mag_a_s[H-1:0]};
        a_h_s = {{H{1'b0}}, mag_a_s[WIDTH-1:H]};
        b_l_s = {{H{1'b0}}, mag_b_s[H-1:0]};
        b_h_s = {{H{1'b0}}, mag_b_s[WIDTH-1:H]};
    end

    // Stage 1 next state: load quadrants on acceptance, bubble when idle, hold on stall
    always_comb begin
        s1_valid_d = s1_valid_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        q3_d       = q3_q;
`ifdef VEDIC_SIGNED_EN
        neg_d      = neg_q;
`endif
        if (!stall_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                q0_d = a_l_s * b_l_s;
                q1_d = a_h_s * b_l_s;
                q2_d = a_l_s * b_h_s;
                q3_d = a_h_s * b_h_s;
`ifdef VEDIC_SIGNED_EN
                neg_d = neg_s;
`endif
            end else begin
                q0_d = q0_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Recombine quadrants over the full 2*WIDTH range; the cross sum may carry past WIDTH bits
    always_comb begin
        sum_raw_s = {ZERO_W, q0_q}
                  + (({ZERO_W, q1_q} + {ZERO_W, q2_q}) << H)
                  + ({ZERO_W, q3_q} << WIDTH);
`ifdef VEDIC_SIGNED_EN
        if (neg_q) begin
            sum_s = ~sum_raw_s + ONE_2W;
        end else begin
            sum_s = sum_raw_s;
        end
`else
        sum_s = sum_raw_s;
`endif
    end

    // Stage 2 next state: product register follows stage 1 unless stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        if (!stall_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_p_d = sum_s;
            end else begin
                out_p_d = out_p_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset clears every valid bit and the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            q0_q        <= ZERO_W;
            q1_q        <= ZERO_W;
            q2_q        <= ZERO_W;
            q3_q        <= ZERO_W;
            out_valid_q <= 1'b0;
            out_p_q     <= ZERO_2W;
        end else begin
            s1_valid_q  <= s1_valid_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            q3_q        <= q3_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
        end
    end

`ifdef VEDIC_SIGNED_EN
    // Negate flag travels with the stage-1 quadrants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe (WIDTH = 32) with a queue-based reference model.
module tb_vedic_mult_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] held_p;

    always #5 clk = ~clk;

    vedic_mult_pipe_if #(.WIDTH(W)) bus ();

    vedic_mult_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] r;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            r  = sa * sb;
        end else begin
            r = {32'd0, a} * {32'd0, b};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    // One clock: drive, check handshake and scoreboard before the edge, check busy after it
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ordy);
        logic [63:0] e;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
`ifdef VEDIC_SIGNED_EN
        bus.in_signed = s;
`endif
        bus.out_ready = ordy;
        #1;
        chk("in_ready_rule", {63'd0, bus.in_ready}, {63'd0, !(bus.out_valid === 1'b1 && !ordy)});
        if (bus.out_valid === 1'b1 && ordy) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_output observed=0x%h expected=no_product", bus.out_p);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("product_order", bus.out_p, e);
            end
        end
        if (v && bus.in_ready === 1'b1) begin
            exp_q.push_back(ref_prod(a, b, s));
        end
        @(posedge clk);
        #1;
        chk("busy", {63'd0, bus.busy}, {63'd0, exp_q.size() > 0});
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
        end
    endtask

    // Isolated pair from an empty pipe: valid only after the second edge, value against a constant
    task automatic lat_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [63:0] expv);
        step(1'b1, a, b, s, 1'b1);
        chk({tag, "_early"}, {63'd0, bus.out_valid}, 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk(tag, bus.out_p, expv);
        drain();
    endtask

    function automatic logic rand_sign();
`ifdef VEDIC_SIGNED_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
`ifdef VEDIC_SIGNED_EN
        bus.in_signed = 1'b0;
`endif
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, bus.busy},      64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_out_p",     bus.out_p,              64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        lat_test("all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        lat_test("zero_x_ff", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0);
        lat_test("one_x_val", 32'h0000_0001, 32'h1234_5678, 1'b0, 64'h0000_0000_1234_5678);
        lat_test("mixed",     32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
`ifdef VEDIC_SIGNED_EN
        lat_test("neg1_x_5",  32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        lat_test("minneg_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
`endif

        for (int i = 0; i < 1000; i++) begin
            step(1'b1, $urandom, $urandom, rand_sign(), 1'b1);
            if (i >= 1) begin
                chk("no_bubble", {63'd0, bus.out_valid}, 64'd1);
            end
        end
        drain();

        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, $urandom, rand_sign(), 1'b1);
        end
        held_p = bus.out_p;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom, $urandom, rand_sign(), 1'b0);
            chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("stall_out_p", bus.out_p, held_p);
            chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, $urandom, rand_sign(), 1'b1);
        end
        drain();

        step(1'b1, $urandom, $urandom, rand_sign(), 1'b1);
        step(1'b1, $urandom, $urandom, rand_sign(), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_busy",      {63'd0, bus.busy},      64'd0);
        chk("midrst_out_p",     bus.out_p,              64'd0);
        chk("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
        end
        lat_test("post_rst", 32'h0000_0003, 32'h0000_0007, 1'b0, 64'd21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
